// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug readback path: memory geometry and the
// dump engine's state encoding.
package mips_dbg_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HALT = 3'd1,
        ST_RD        = 3'd2,
        ST_CAP       = 3'd3,
        ST_SEND      = 3'd4,
        ST_FIN       = 3'd5
    } dump_state_e;

endpackage

// File: rtl/mem_dump_unit.sv
// Walks a data-memory range after the core halts and streams each word out
// with the address it came from.
module mem_dump_unit
    import mips_dbg_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int CNT_W  = 11
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              halted,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output dump_state_e       dbg_state
);

    // Stream handshake: a word transfers on a rising clk1 edge where out_valid
    // and out_ready are both 1; out_valid/out_data/out_addr hold until then.

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic              xfer;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remain_q    <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remain_q    <= remain_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remain_d    = remain_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        xfer        = out_valid_q && out_ready;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d = base_addr;
                    remain_d   = word_count;
                    err_d      = 1'b0;
                    if (word_count == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_WAIT_HALT;
                    end
                end
            end
            ST_WAIT_HALT: begin
                if (halted) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                // A core that resumed between words must not be read under.
                if (halted) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = cur_addr_q;
                    state_d   = ST_CAP;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_CAP: begin
                out_data_d  = mem_rd_data;
                out_addr_d  = cur_addr_q;
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remain_d    = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Bench for mem_dump_unit: behavioural memory, scoreboard of expected
// (address, data) words, directed scenarios plus randomized dumps.
module tb_mem_dump_unit;
    import mips_dbg_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 11;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          halted;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          err;
    dump_state_e   dbg_state;

    logic [DW-1:0]    mem [1024];
    logic [AW+DW-1:0] exp_q[$];
    int               rd_q[$];
    int               vld_q[$];
    int               hs_q[$];
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               done_cnt = 0;
    logic             done_err = 1'b0;

    logic             prev_stall = 1'b0;
    logic             prev_valid = 1'b0;
    logic [DW-1:0]    held_data;
    logic [AW-1:0]    held_addr;
    logic [AW+DW-1:0] mon_e;

    mem_dump_unit #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk1(clk1), .rst(rst), .halted(halted), .start(start),
        .base_addr(base_addr), .word_count(word_count),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    // Synchronous read port: data appears the cycle after the strobe.
    always @(posedge clk1) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    initial begin
        #900000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk1) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (mem_rd_en) begin
                rd_q.push_back(cyc);
                chk("rd_only_when_halted", halted, 1);
            end
            if (out_valid && !prev_valid) vld_q.push_back(cyc);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held_data);
                chk("hold_addr", out_addr, held_addr);
            end
            if (out_valid && out_ready) begin
                hs_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word act=%0h:%0h exp=none", out_addr, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_addr", out_addr, mon_e[AW+DW-1:DW]);
                    chk("word_data", out_data, mon_e[DW-1:0]);
                end
            end
            if (done) begin
                done_cnt++;
                done_err = err;
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            held_data  = out_data;
            held_addr  = out_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        vld_q.delete();
        hs_q.delete();
    endtask

    task automatic push_words(input int b, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = AW'(b + i);
            exp_q.push_back({a, mem[a]});
        end
    endtask

    task automatic pulse_start(input int b, input int n, output int sc);
        base_addr  = AW'(b);
        word_count = CW'(n);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        sc         = cyc;
    endtask

    task automatic wait_done(input int budget, input bit rnd, input int d0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            if (rnd) out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout act=no_done exp=done budget=%0d", budget);
        end
    endtask

    task automatic wait_valid(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (vld_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout act=no_valid exp=valid budget=%0d", budget);
        end
    endtask

    task automatic run_dump(input int b, input int n, input bit rnd, input bit exp_err, output int sc);
        int d0;
        d0 = done_cnt;
        clear_logs();
        push_words(b, n);
        pulse_start(b, n, sc);
        chk("err_cleared_by_start", err, 0);
        wait_done(n * 40 + 50, rnd, d0);
        tick();
        tick();
        chk("done_once", done_cnt - d0, 1);
        chk("err_at_done", done_err, exp_err);
        chk("sb_drained", exp_q.size(), 0);
        chk("idle_after", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sc, h, b, n, d0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[198] = 32'd120;
        mem[200] = 32'd5;
        rst = 1'b1; halted = 1'b0; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; word_count = '0;
        repeat (3) @(posedge clk1);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        tick();

        // Factorial readback, ready always high.
        halted = 1'b1; out_ready = 1'b1;
        run_dump(198, 3, 1'b0, 1'b0, sc);
        chk("fact_valid_cnt", vld_q.size(), 3);
        if (vld_q.size() == 3) begin
            chk("fact_latency", vld_q[0] - sc, 3);
            chk("fact_gap01", vld_q[1] - vld_q[0], 3);
            chk("fact_gap12", vld_q[2] - vld_q[1], 3);
        end

        // Wait for halt.
        halted = 1'b0; out_ready = 1'b1;
        d0 = done_cnt;
        clear_logs();
        push_words(100, 1);
        pulse_start(100, 1, sc);
        repeat (50) tick();
        chk("no_rd_before_halt", rd_q.size(), 0);
        chk("busy_waiting", busy, 1);
        halted = 1'b1;
        h = cyc;
        wait_done(60, 1'b0, d0);
        chk("halt_rd_cnt", rd_q.size(), 1);
        if (rd_q.size() > 0 && vld_q.size() > 0) begin
            chk("rd_after_halt", rd_q[0] - h, 1);
            chk("valid_after_rd", vld_q[0] - rd_q[0], 2);
        end
        tick();

        // Backpressure on word 0.
        b = $urandom_range(0, 1023);
        out_ready = 1'b0;
        d0 = done_cnt;
        clear_logs();
        push_words(b, 2);
        pulse_start(b, 2, sc);
        wait_valid(20);
        repeat (7) tick();
        chk("bp_one_read", rd_q.size(), 1);
        out_ready = 1'b1;
        wait_done(60, 1'b0, d0);
        chk("bp_reads", rd_q.size(), 2);
        chk("bp_xfers", hs_q.size(), 2);
        if (rd_q.size() == 2 && hs_q.size() > 0) chk("bp_rd_after_hs", rd_q[1] - hs_q[0], 1);
        chk("bp_sb_drained", exp_q.size(), 0);
        tick();

        // Zero-length dump.
        run_dump(5, 0, 1'b0, 1'b0, sc);
        chk("zero_no_rd", rd_q.size(), 0);
        chk("zero_no_valid", vld_q.size(), 0);

        // Address wrap.
        run_dump(1023, 2, 1'b0, 1'b0, sc);

        // Abort by halted drop during SEND of word 0.
        b = $urandom_range(0, 1023);
        out_ready = 1'b0;
        d0 = done_cnt;
        clear_logs();
        push_words(b, 1);
        pulse_start(b, 4, sc);
        wait_valid(20);
        halted = 1'b0;
        tick();
        out_ready = 1'b1;
        wait_done(40, 1'b0, d0);
        tick();
        chk("abort_err_at_done", done_err, 1);
        chk("abort_err_sticky", err, 1);
        chk("abort_reads", rd_q.size(), 1);
        chk("abort_sb_drained", exp_q.size(), 0);
        halted = 1'b1;
        run_dump($urandom_range(0, 1023), 1, 1'b0, 1'b0, sc);
        chk("err_after_restart", err, 0);

        // Asynchronous reset mid-SEND.
        b = $urandom_range(0, 1023);
        out_ready = 1'b0;
        clear_logs();
        push_words(b, 3);
        pulse_start(b, 3, sc);
        wait_valid(20);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_state", dbg_state, ST_IDLE);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        // Randomized dumps with random backpressure.
        for (int k = 0; k < 8; k++) begin
            n = (k == 7) ? 20 : $urandom_range(1, 6);
            run_dump($urandom_range(0, 1023), n, 1'b1, 1'b0, sc);
            chk("rand_xfers", hs_q.size(), n);
            out_ready = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
